// File: rtl/cor_peak.sv
// Correlation peak search: after a rising edge on full, sweeps every lag of the template
// across the capture buffer, accumulates the dot product, and keeps the earliest maximum.
module cor_peak #(
  parameter int unsigned buf_size     = 500,
  parameter int unsigned buf_size_MSB = 8,
  parameter int unsigned tmpl_len     = 64,
  parameter int unsigned tmpl_MSB     = 5,
  parameter int unsigned data_w       = 12,
  localparam int unsigned num_lags    = buf_size - tmpl_len + 1,
  localparam int unsigned acc_w       = 2 * data_w + tmpl_MSB + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      full,
  output logic [buf_size_MSB:0]     rd_address,
  input  logic signed [data_w-1:0]  rd_data,
  output logic [tmpl_MSB:0]         tmpl_address,
  input  logic signed [data_w-1:0]  tmpl_data,
  output logic                      busy,
  output logic                      done,
  output logic [buf_size_MSB:0]     peak_lag,
  output logic signed [acc_w-1:0]   peak_value
);

  localparam int unsigned LagW = buf_size_MSB + 1;
  localparam int unsigned KW   = tmpl_MSB + 1;
  localparam int unsigned PW   = 2 * data_w;

  typedef enum logic [2:0] {StIdle, StRun, StFlush, StCmp, StDone} state_e;

  state_e                   state_q, state_d;
  logic                     full_dly_q;
  logic [LagW-1:0]          lag_q, lag_d;
  logic [KW-1:0]            k_q, k_d;
  logic                     flush_q, flush_d;
  logic                     v1_q, v1_d, v2_q, v2_d;
  logic signed [PW-1:0]     prod_q, prod_d;
  logic signed [acc_w-1:0]  acc_q, acc_d;
  logic signed [acc_w-1:0]  cand_val_q, cand_val_d;
  logic [LagW-1:0]          cand_lag_q, cand_lag_d;
  logic signed [acc_w-1:0]  peak_value_q, peak_value_d;
  logic [LagW-1:0]          peak_lag_q, peak_lag_d;

  logic signed [PW-1:0]     product;
  logic signed [acc_w-1:0]  prod_ext;
  logic                     take;

  always_comb begin
    state_d      = state_q;
    lag_d        = lag_q;
    k_d          = k_q;
    flush_d      = flush_q;
    cand_val_d   = cand_val_q;
    cand_lag_d   = cand_lag_q;
    peak_value_d = peak_value_q;
    peak_lag_d   = peak_lag_q;

    // v1 marks memory data valid this cycle, v2 marks prod_q valid this cycle.
    product  = rd_data * tmpl_data;
    v1_d     = (state_q == StRun);
    v2_d     = v1_q;
    prod_d   = v1_q ? product : '0;
    prod_ext = {{(acc_w - PW){prod_q[PW-1]}}, prod_q};
    acc_d    = v2_q ? acc_q + prod_ext : acc_q;
    take     = (lag_q == '0) || (acc_q > cand_val_q);

    unique case (state_q)
      StIdle: begin
        // Flush the pipeline so an aborted search cannot leak products into the next one.
        v1_d   = 1'b0;
        v2_d   = 1'b0;
        prod_d = '0;
        acc_d  = '0;
        if (full && !full_dly_q) begin
          state_d = StRun;
          lag_d   = '0;
          k_d     = '0;
        end
      end
      StRun: begin
        if (!full) begin
          state_d = StIdle;
        end else begin
          k_d = k_q + KW'(1);
          if (k_q == KW'(tmpl_len - 1)) begin
            state_d = StFlush;
            flush_d = 1'b0;
          end
        end
      end
      StFlush: begin
        if (!full) begin
          state_d = StIdle;
        end else if (flush_q) begin
          state_d = StCmp;
        end else begin
          flush_d = 1'b1;
        end
      end
      StCmp: begin
        if (!full) begin
          state_d = StIdle;
        end else begin
          if (take) begin
            cand_val_d = acc_q;
            cand_lag_d = lag_q;
          end
          acc_d = '0;
          k_d   = '0;
          if (lag_q == LagW'(num_lags - 1)) begin
            state_d      = StDone;
            peak_lag_d   = take ? lag_q : cand_lag_q;
            peak_value_d = take ? acc_q : cand_val_q;
          end else begin
            lag_d   = lag_q + LagW'(1);
            state_d = StRun;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      full_dly_q   <= 1'b0;
      lag_q        <= '0;
      k_q          <= '0;
      flush_q      <= 1'b0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      prod_q       <= '0;
      acc_q        <= '0;
      cand_val_q   <= '0;
      cand_lag_q   <= '0;
      peak_value_q <= '0;
      peak_lag_q   <= '0;
    end else begin
      state_q      <= state_d;
      full_dly_q   <= full;
      lag_q        <= lag_d;
      k_q          <= k_d;
      flush_q      <= flush_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      prod_q       <= prod_d;
      acc_q        <= acc_d;
      cand_val_q   <= cand_val_d;
      cand_lag_q   <= cand_lag_d;
      peak_value_q <= peak_value_d;
      peak_lag_q   <= peak_lag_d;
    end
  end

  always_comb begin
    rd_address   = '0;
    tmpl_address = '0;
    if (state_q == StRun) begin
      rd_address   = lag_q + LagW'(k_q);
      tmpl_address = k_q;
    end
    busy       = (state_q == StRun) || (state_q == StFlush) || (state_q == StCmp);
    done       = (state_q == StDone);
    peak_lag   = peak_lag_q;
    peak_value = peak_value_q;
  end

endmodule

// File: tb/tb_cor_peak.sv
// Bench for cor_peak: a small instance (8-sample buffer, 3-tap template) for directed and random
// searches, and a default-size instance for the full-width and full-length checks.
module tb_cor_peak;

  localparam int SB   = 8;
  localparam int ST   = 3;
  localparam int DB   = 500;
  localparam int DT   = 64;
  localparam int SCYC = (SB - ST + 1) * (ST + 3);
  localparam int LCYC = (DB - DT + 1) * (DT + 3);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic full_s = 1'b0;
  logic full_l = 1'b0;

  logic [2:0]          rd_addr_s;
  logic [1:0]          t_addr_s;
  logic signed [11:0]  rd_data_s, t_data_s;
  logic                busy_s, done_s;
  logic [2:0]          plag_s;
  logic signed [25:0]  pval_s;

  logic [8:0]          rd_addr_l;
  logic [5:0]          t_addr_l;
  logic signed [11:0]  rd_data_l, t_data_l;
  logic                busy_l, done_l;
  logic [8:0]          plag_l;
  logic signed [29:0]  pval_l;

  logic signed [11:0] mem_bs [8];
  logic signed [11:0] mem_ts [4];
  logic signed [11:0] mem_bl [512];
  logic signed [11:0] mem_tl [64];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_data_s <= mem_bs[rd_addr_s];
    t_data_s  <= mem_ts[t_addr_s];
    rd_data_l <= mem_bl[rd_addr_l];
    t_data_l  <= mem_tl[t_addr_l];
  end

  cor_peak #(
    .buf_size(SB), .buf_size_MSB(2), .tmpl_len(ST), .tmpl_MSB(1), .data_w(12)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .full(full_s),
    .rd_address(rd_addr_s), .rd_data(rd_data_s),
    .tmpl_address(t_addr_s), .tmpl_data(t_data_s),
    .busy(busy_s), .done(done_s), .peak_lag(plag_s), .peak_value(pval_s)
  );

  cor_peak u_large (
    .clk(clk), .rst_n(rst_n), .full(full_l),
    .rd_address(rd_addr_l), .rd_data(rd_data_l),
    .tmpl_address(t_addr_l), .tmpl_data(t_data_l),
    .busy(busy_l), .done(done_l), .peak_lag(plag_l), .peak_value(pval_l)
  );

  task automatic chk(input string tag, input string what, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s: observed %0d expected %0d", tag, what, obs, exp);
    end
  endtask

  // Reference: direct sum of products per lag; earliest lag wins ties.
  function automatic void model(input int b[$], input int t[$], output int lag,
                                output longint val);
    longint s;
    lag = 0;
    val = 0;
    for (int l = 0; l <= b.size() - t.size(); l++) begin
      s = 0;
      for (int j = 0; j < t.size(); j++) s += longint'(b[l + j]) * longint'(t[j]);
      if (l == 0 || s > val) begin
        val = s;
        lag = l;
      end
    end
  endfunction

  task automatic load_s(input int b[$], input int t[$]);
    foreach (b[i]) mem_bs[i] = 12'(b[i]);
    foreach (t[i]) mem_ts[i] = 12'(t[i]);
  endtask

  task automatic load_l(input int b[$], input int t[$]);
    foreach (b[i]) mem_bl[i] = 12'(b[i]);
    foreach (t[i]) mem_tl[i] = 12'(t[i]);
  endtask

  // Called at #1 after E0 on the small instance.
  task automatic wait_small(input string tag, input int exp_lag, input longint exp_val);
    int cyc;
    bit got;
    chk(tag, "busy_rise", busy_s, 1);
    cyc = 0;
    got = 0;
    while (!got && cyc < SCYC + 50) begin
      @(posedge clk);
      cyc++;
      #1;
      got = done_s;
    end
    chk(tag, "done_cycle", cyc, SCYC);
    chk(tag, "peak_lag", plag_s, exp_lag);
    chk(tag, "peak_value", pval_s, exp_val);
    chk(tag, "busy_in_done", busy_s, 0);
    @(posedge clk);
    #1;
    chk(tag, "done_one_cycle", done_s, 0);
  endtask

  task automatic run_small(input string tag, input int exp_lag, input longint exp_val);
    @(negedge clk) full_s = 1'b1;
    @(posedge clk);
    #1;
    wait_small(tag, exp_lag, exp_val);
  endtask

  task automatic run_large(input string tag, input int exp_lag, input longint exp_val);
    int cyc;
    bit got;
    @(negedge clk) full_l = 1'b1;
    @(posedge clk);
    #1;
    chk(tag, "busy_rise", busy_l, 1);
    cyc = 0;
    got = 0;
    while (!got && cyc < LCYC + 100) begin
      @(posedge clk);
      cyc++;
      #1;
      got = done_l;
    end
    chk(tag, "done_cycle", cyc, LCYC);
    chk(tag, "peak_lag", plag_l, exp_lag);
    chk(tag, "peak_value", pval_l, exp_val);
    @(negedge clk) full_l = 1'b0;
    @(posedge clk);
  endtask

  task automatic drop_s();
    @(negedge clk) full_s = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    int b[$];
    int t[$];
    int elag;
    longint eval;
    int seen;

    #1 rst_n = 1'b0;
    #1;
    chk("reset", "busy", busy_s, 0);
    chk("reset", "done", done_s, 0);
    chk("reset", "peak_lag", plag_s, 0);
    chk("reset", "peak_value", pval_s, 0);
    chk("reset", "rd_address", rd_addr_s, 0);
    chk("reset", "tmpl_address", t_addr_s, 0);
    chk("reset", "busy_large", busy_l, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);

    // All ones, then full held high must not retrigger.
    b.delete(); t.delete();
    for (int i = 0; i < SB; i++) b.push_back(1);
    for (int i = 0; i < ST; i++) t.push_back(1);
    load_s(b, t);
    run_small("ones", 0, 3);
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      seen += int'(busy_s | done_s);
    end
    chk("ones", "no_retrigger", seen, 0);
    drop_s();

    // Embedded pattern.
    b.delete(); t.delete();
    for (int i = 0; i < SB; i++) b.push_back(0);
    b[4] = 1; b[5] = 2; b[6] = 3;
    t.push_back(1); t.push_back(2); t.push_back(3);
    load_s(b, t);
    run_small("embed", 4, 14);
    drop_s();

    // All negative: every lag ties, earliest wins.
    b.delete(); t.delete();
    for (int i = 0; i < SB; i++) b.push_back(-5);
    for (int i = 0; i < ST; i++) t.push_back(1);
    load_s(b, t);
    run_small("neg", 0, -15);
    drop_s();

    // Abort: load the embedded pattern so a leaked result would differ.
    b.delete(); t.delete();
    for (int i = 0; i < SB; i++) b.push_back(0);
    b[4] = 1; b[5] = 2; b[6] = 3;
    t.push_back(1); t.push_back(2); t.push_back(3);
    load_s(b, t);
    @(negedge clk) full_s = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk) full_s = 1'b0;
    @(posedge clk);
    #1;
    chk("abort", "busy_drop", busy_s, 0);
    seen = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      seen += int'(done_s);
    end
    chk("abort", "no_done", seen, 0);
    chk("abort", "peak_lag_kept", plag_s, 0);
    chk("abort", "peak_value_kept", pval_s, -15);
    run_small("restart", 4, 14);
    drop_s();

    // Asynchronous reset mid-run, then restart with full still high.
    @(negedge clk) full_s = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid", "busy", busy_s, 0);
    chk("rst_mid", "done", done_s, 0);
    chk("rst_mid", "peak_lag", plag_s, 0);
    chk("rst_mid", "peak_value", pval_s, 0);
    chk("rst_mid", "rd_address", rd_addr_s, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    wait_small("rst_restart", 4, 14);
    drop_s();

    // Random data; odd iterations use a narrow range so ties are common.
    for (int it = 0; it < 12; it++) begin
      b.delete(); t.delete();
      for (int i = 0; i < SB; i++)
        b.push_back(it[0] ? int'($urandom_range(4)) - 2 : int'($urandom_range(4095)) - 2048);
      for (int i = 0; i < ST; i++)
        t.push_back(it[0] ? int'($urandom_range(4)) - 2 : int'($urandom_range(4095)) - 2048);
      load_s(b, t);
      model(b, t, elag, eval);
      run_small($sformatf("rand%0d", it), elag, eval);
      drop_s();
    end

    // Full-size width check.
    b.delete(); t.delete();
    for (int i = 0; i < DB; i++) b.push_back(-2048);
    for (int i = 0; i < DT; i++) t.push_back(-2048);
    load_l(b, t);
    run_large("width", 0, 268435456);

    b.delete(); t.delete();
    for (int i = 0; i < DB; i++) b.push_back(int'($urandom_range(4095)) - 2048);
    for (int i = 0; i < DT; i++) t.push_back(int'($urandom_range(4095)) - 2048);
    load_l(b, t);
    model(b, t, elag, eval);
    run_large("rand_large", elag, eval);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cor_peak.md
# cor_peak

Correlation peak search stage placed directly downstream of the capture-buffer write stage. Once the sample buffer reports `full`, the block reads the buffer and a reference template from two synchronous memories. It computes the cross-correlation at every valid lag and reports the lag and value of the maximum. Results are held until the next completed search and are consumed by the distance/direction logic.

## Interface
- `buf_size`, 500, number of samples in the capture buffer.
- `buf_size_MSB`, 8, MSB index of buffer addresses and lags.
- `tmpl_len`, 64, number of template samples; must be ≤ `buf_size`.
- `tmpl_MSB`, 5, MSB index of template addresses.
- `data_w`, 12, width of signed buffer and template samples.
- Derived, not overridable:
  - `num_lags` = `buf_size` − `tmpl_len` + 1.
  - `acc_w` = 2·`data_w` + `tmpl_MSB` + 1.

- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `full`  in  1  buffer-complete flag from the write stage; its rising edge starts a search.
- `rd_address`  out  buf_size_MSB+1  buffer read address.
- `rd_data`  in  data_w  signed buffer sample; valid one cycle after `rd_address`.
- `tmpl_address`  out  tmpl_MSB+1  template read address.
- `tmpl_data`  in  data_w  signed template sample; valid one cycle after `tmpl_address`.
- `busy`  out  1  high while a search is in progress.
- `done`  out  1  one-cycle pulse when results update.
- `peak_lag`  out  buf_size_MSB+1  lag of the maximum correlation.
- `peak_value`  out  acc_w  signed maximum correlation value.

## Operation
- Edge detect:
  - `full_d` is a register of `full`; its reset value is 0.
  - Start condition is `full & !full_d`.
  - If `full` is already high when reset is released, that counts as an edge.
- States:
  - IDLE: waits for the start condition. On start, go to RUN with lag=0, k=0, acc=0.
  - RUN: drives `rd_address`=lag+k and `tmpl_address`=k. k advances each cycle. After k=`tmpl_len`−1 is issued, go to FLUSH.
  - FLUSH: lasts 2 cycles, covering memory latency and the product register. Accumulation continues until the last product is summed.
  - CMP: lasts 1 cycle.
    - At lag 0, the candidate is loaded unconditionally with acc and lag.
    - At other lags, the candidate updates only if acc > candidate (strict, signed).
    - acc is then cleared and k reset to 0.
    - If lag = `num_lags`−1, go to DONE; otherwise increment lag and go to RUN.
  - DONE: lasts 1 cycle. Copy the candidate to `peak_lag`/`peak_value`, pulse `done`, then go to IDLE.
- Arithmetic:
  - The product is 2·`data_w` bits, signed, sign-extended to `acc_w`.
  - No overflow is possible at declared widths; no saturation logic.
- Ties: the earliest lag wins.
- Abort: if `full` is sampled low in any state other than IDLE or DONE, go to IDLE next cycle.
  - `done` does not pulse.
  - `peak_lag`/`peak_value` keep their previous values.
  - The candidate is discarded.
- `full` staying high after DONE does not retrigger; a new search needs a new rising edge.
- Address outputs are don't-care outside RUN but are held at 0 in IDLE.

## Timing
- Reset values: `busy`=0, `done`=0, `peak_lag`=0, `peak_value`=0, `rd_address`=0, `tmpl_address`=0, state=IDLE.
- `rst_n` low mid-search clears everything asynchronously. No `done` is produced.
- Let E0 be the clock edge at which the start condition is sampled.
- `busy` goes high after E0 and stays high through the last CMP cycle. It is low in DONE and IDLE.
- Each lag takes `tmpl_len`+3 cycles.
- `done` is high for exactly the one cycle beginning `num_lags`·(`tmpl_len`+3) edges after E0.
- `peak_lag`/`peak_value` change in the same cycle `done` rises.
- Default parameters: 437·67 = 29279 cycles per search.
- Memory read latency is exactly 1 cycle; no handshake on the read ports.

## Test plan
- All-ones data: `buf_size`=8, `tmpl_len`=3, buffer and template all +1, rising `full`:
  - `done` 36 cycles after E0.
  - `peak_lag`=0, `peak_value`=3.
  - `busy` high for 35 cycles.
- Embedded pattern: same parameters, template [1,2,3], buffer 0 except addresses 4,5,6 = 1,2,3 -> `peak_lag`=4, `peak_value`=14.
- All-negative correlation: buffer all −5, template all +1 -> `peak_lag`=0 (tie, earliest), `peak_value`=−15.
- Abort: after a completed run, drop `full` 10 cycles after a new E0:
  - `busy` low within 1 cycle.
  - No `done` pulse.
  - `peak_*` unchanged.
  - A new `full` edge restarts and completes normally.
- Reset mid-run: assert `rst_n`=0 at cycle 20 -> all outputs 0 immediately, without waiting for a clock edge. After release with `full` high, a search starts.
- Width check: default parameters, all samples −2048 -> `peak_value`=+268435456 (2^28), `peak_lag`=0, `done` at 29279 cycles.
